// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache with 4-word blocks.
// Hits return combinationally; misses stall the PC while a block is refilled.
module instruction_cache #(
    parameter int N          = 32,
    parameter int INDEX_BITS = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   pc,
    output logic [31:0]    instruction,
    output logic           busywait,
    output logic           mem_read,
    output logic [N-5:0]   mem_address,
    input  logic [127:0]   mem_readdata,
    input  logic           mem_busywait
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = N - INDEX_BITS - 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        MEM_READ,
        FILL
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [LINES-1:0]       r_valid;
    logic [TAG_W-1:0]       r_tag [LINES];
    logic [127:0]           r_data [LINES];
    logic [127:0]           r_fill_buf;

    logic [INDEX_BITS-1:0]  w_index;
    logic [TAG_W-1:0]       w_tag;
    logic [1:0]             w_offset;
    logic                   w_hit;
    logic [31:0]            w_word;
    logic                   w_fill_we;
    logic                   w_unused_pc;

    assign w_index     = pc[INDEX_BITS+3:4];
    assign w_tag       = pc[N-1:INDEX_BITS+4];
    assign w_offset    = pc[3:2];
    assign w_unused_pc = ^pc[1:0];
    assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_word      = r_data[w_index][{w_offset, 5'd0} +: 32];
    // A reset landing on the FILL edge must not leave a half-committed line.
    assign w_fill_we   = (r_state == FILL) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_valid <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == FILL) begin
                r_valid[w_index] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == MEM_READ && !mem_busywait) begin
            r_fill_buf <= mem_readdata;
        end
        if (w_fill_we) begin
            r_data[w_index] <= r_fill_buf;
            r_tag[w_index]  <= w_tag;
        end
    end

    always_comb begin
        w_next_state = r_state;
        instruction  = NOP;
        busywait     = 1'b0;
        mem_read     = 1'b0;
        mem_address  = '0;
        case (r_state)
            IDLE: begin
                if (w_hit) begin
                    instruction = w_word;
                end else begin
                    busywait     = 1'b1;
                    w_next_state = MEM_READ;
                end
            end
            MEM_READ: begin
                busywait    = 1'b1;
                mem_read    = 1'b1;
                mem_address = pc[N-1:4];
                if (!mem_busywait) begin
                    w_next_state = FILL;
                end
            end
            FILL: begin
                busywait     = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instruction_cache.sv
// Randomized bench for instruction_cache against a line-level behavioural model
// and a memory that answers after a chosen number of busy cycles.
module tb_instruction_cache;

    localparam int N          = 32;
    localparam int INDEX_BITS = 3;
    localparam int LINES      = 1 << INDEX_BITS;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  pc;
    logic [31:0]   instruction;
    logic          busywait;
    logic          mem_read;
    logic [N-5:0]  mem_address;
    logic [127:0]  mem_readdata;
    logic          mem_busywait;

    int n_checks = 0;
    int n_errors = 0;

    logic         m_valid [LINES];
    int unsigned  m_tag   [LINES];
    logic [127:0] m_data  [LINES];

    instruction_cache #(.N(N), .INDEX_BITS(INDEX_BITS)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .instruction  (instruction),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] mem_block(input int unsigned baddr);
        logic [127:0] b;
        if (baddr == 0) begin
            b = {32'h0000_0013, 32'h0020_81B3, 32'h0020_0113, 32'h0040_0093};
        end else begin
            for (int k = 0; k < 4; k++) begin
                b[32*k +: 32] = 32'hC000_0000 ^ (baddr * 32'h0001_0011) ^ (k * 32'h0000_0101);
            end
        end
        return b;
    endfunction

    // Advance to 1 time unit after the next rising edge (the drive window).
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endtask

    // Called in the drive window; returns in the drive window of the cycle after the fetch completes.
    task automatic fetch(input logic [31:0] p, input int lat);
        int unsigned idx, tg, wd, baddr;
        logic [31:0] exp_word;
        baddr = p / 16;
        idx   = baddr % LINES;
        tg    = p / (16 * LINES);
        wd    = (p / 4) % 4;
        pc    = p;
        mem_busywait = 1'b1;
        mem_readdata = {$urandom, $urandom, $urandom, $urandom};
        #1;
        if (m_valid[idx] && m_tag[idx] == tg) begin
            exp_word = m_data[idx][32*wd +: 32];
            check_eq("hit_busywait", {31'd0, busywait}, 32'd0);
            check_eq("hit_instr", instruction, exp_word);
            check_eq("hit_mem_read", {31'd0, mem_read}, 32'd0);
            next_cycle();
            return;
        end
        check_eq("miss_busywait", {31'd0, busywait}, 32'd1);
        check_eq("miss_instr", instruction, NOP);
        check_eq("miss_mem_read", {31'd0, mem_read}, 32'd0);
        for (int k = 0; k <= lat; k++) begin
            next_cycle();
            mem_busywait = (k < lat);
            mem_readdata = (k == lat) ? mem_block(baddr) : {$urandom, $urandom, $urandom, $urandom};
            #1;
            check_eq("rd_mem_read", {31'd0, mem_read}, 32'd1);
            check_eq("rd_mem_addr", {4'd0, mem_address}, p >> 4);
            check_eq("rd_busywait", {31'd0, busywait}, 32'd1);
            check_eq("rd_instr", instruction, NOP);
        end
        next_cycle();
        mem_busywait = 1'b1;
        mem_readdata = {$urandom, $urandom, $urandom, $urandom};
        #1;
        check_eq("fill_mem_read", {31'd0, mem_read}, 32'd0);
        check_eq("fill_mem_addr", {4'd0, mem_address}, 32'd0);
        check_eq("fill_busywait", {31'd0, busywait}, 32'd1);
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        m_data[idx]  = mem_block(baddr);
        next_cycle();
        #1;
        exp_word = m_data[idx][32*wd +: 32];
        check_eq("post_busywait", {31'd0, busywait}, 32'd0);
        check_eq("post_instr", instruction, exp_word);
        check_eq("post_mem_read", {31'd0, mem_read}, 32'd0);
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p;
        reset        = 1'b1;
        pc           = '0;
        mem_busywait = 1'b1;
        mem_readdata = '0;
        model_reset();
        next_cycle();
        next_cycle();
        check_eq("rst_mem_read", {31'd0, mem_read}, 32'd0);
        check_eq("rst_mem_addr", {4'd0, mem_address}, 32'd0);
        check_eq("rst_busywait", {31'd0, busywait}, 32'd1);
        check_eq("rst_instr", instruction, NOP);
        reset = 1'b0;

        // Cold miss with 5 busy cycles, then sequential hits through the block.
        fetch(32'h0, 5);
        fetch(32'h4, 0);
        fetch(32'h8, 0);
        fetch(32'hC, 0);

        // Conflict on index 0: tag 1 evicts tag 0, then tag 0 misses again.
        fetch(32'h80, 2);
        fetch(32'h0, 1);

        // Reset during the third MEM_READ cycle aborts the refill.
        fetch(32'h20, 1);
        pc = 32'h40;
        mem_busywait = 1'b1;
        #1;
        check_eq("abort_miss", {31'd0, busywait}, 32'd1);
        next_cycle();
        next_cycle();
        next_cycle();
        check_eq("abort_rd3", {31'd0, mem_read}, 32'd1);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        model_reset();
        #1;
        check_eq("abort_mem_read", {31'd0, mem_read}, 32'd0);
        check_eq("abort_busywait", {31'd0, busywait}, 32'd1);
        #1;
        fetch(32'h0, 3);
        fetch(32'h20, 0);
        fetch(32'h40, 2);

        // Zero-latency memory.
        for (int i = 0; i < 6; i++) begin
            p = ($urandom_range(4, 7) << 7) | ($urandom_range(0, 7) << 4) | $urandom_range(0, 15);
            fetch(p, 0);
        end

        // Index wrap: last line and line 0 are independent.
        fetch(32'h70, 1);
        fetch(32'h80, 1);
        fetch(32'h70, 0);
        fetch(32'h80, 0);
        fetch(32'h74, 0);

        // Random mix of hits, conflicts and latencies over a small tag set.
        for (int i = 0; i < 80; i++) begin
            p = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4) | $urandom_range(0, 15);
            fetch(p, $urandom_range(0, 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instruction_cache.md
# instruction_cache

Direct-mapped, read-only instruction cache between `program_counter` and the slow instruction memory. It looks up the current PC each cycle, returns the instruction combinationally on a hit, and on a miss stalls the PC through `busywait` while it refills a 4-word block. `busywait` drives `program_counter.wait_until_next_cycle_flag`.

## Interface
- `N`, default 32: PC/address width.
- `INDEX_BITS`, default 3: index width, giving 2^INDEX_BITS lines. Block size is fixed at 4 words (16 bytes).
- `clk`  in  1: single clock. All state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `pc`  in  N: byte address from `program_counter.pc_out`.
- `instruction`  out  32: fetched instruction.
- `busywait`  out  1: stall request to `program_counter`.
- `mem_read`  out  1: refill request to instruction memory.
- `mem_address`  out  N-4: block address.
- `mem_readdata`  in  128: refill block. Word k is `mem_readdata[32k+31:32k]`.
- `mem_busywait`  in  1: memory is not ready. Low in a MEM_READ cycle means `mem_readdata` is valid in that cycle.

## Operation
- **Address split**
  - `pc[1:0]` is ignored (word-aligned truncation).
  - Word offset = `pc[3:2]`.
  - Index = `pc[INDEX_BITS+3:4]`.
  - Tag = `pc[N-1:INDEX_BITS+4]` (25 bits at default parameters).
- **Storage per line:** valid bit, tag, 128-bit data. All valid bits are cleared on reset; tags and data are not reset.
- **Hit** = `valid[index] && tag[index] == pc tag`, evaluated combinationally.
- **FSM states:** IDLE, MEM_READ, FILL.
  - **IDLE**
    - Hit: `instruction` = selected word, `busywait` = 0.
    - Miss: `busywait` = 1 in the same cycle; next state is MEM_READ.
  - **MEM_READ**
    - Outputs: `mem_read` = 1, `mem_address` = `pc[N-1:4]`, `busywait` = 1.
    - On an edge with `mem_busywait` = 0: capture `mem_readdata` into a fill buffer and go to FILL.
    - Otherwise stay in MEM_READ.
  - **FILL**
    - Outputs: `mem_read` = 0, `busywait` = 1.
    - At the edge: write the fill buffer, the tag, and valid = 1 into line[index]; go to IDLE.
- **`instruction` when `busywait` = 1:** 32'h00000013 (NOP, `addi x0,x0,0`), so the single-cycle datapath performs no architectural write.
- **`mem_address` when `mem_read` = 0:** 0.
- **PC stability:** `pc` stays stable while `busywait` = 1, because the PC is frozen. The block does not re-check `pc` during MEM_READ or FILL.
- **Replacement:** a conflict miss overwrites the line unconditionally. There is no write path.

## Timing
- **Reset values (edge with `reset` = 1):**
  - State = IDLE, all valid bits = 0.
  - `mem_read` = 0, `mem_address` = 0.
  - `busywait` follows the IDLE lookup: 1 if the current `pc` misses, which is always true immediately after reset.
- **Reset mid-miss:** reset in MEM_READ or FILL aborts the refill.
  - No line is written.
  - `mem_read` is 0 in the cycle after the reset edge.
  - Reset has priority over every transition.
- **Hit latency:** 0 cycles (combinational). The PC advances at the same edge.
- **Miss stall:** let the memory hold `mem_busywait` = 1 for L MEM_READ cycles, then drive 0 for one cycle.
  - `busywait` = 1 for L+3 cycles: 1 IDLE-miss cycle + (L+1) MEM_READ cycles + 1 FILL cycle.
  - The following IDLE cycle hits, and the PC advances at its edge.
- **Zero-latency memory** (`mem_busywait` = 0 in the first MEM_READ cycle) is legal: the stall is exactly 3 cycles.
- **`mem_read` duration:** high for exactly L+1 consecutive cycles per miss. It never stays high in FILL or IDLE.
- **Index wrap:** index field 2^INDEX_BITS−1 and index 0 are independent lines. There is no adjacency effect.

## Test plan
1. **Cold miss:** reset; `pc`=0x0; memory L=5 returns block {0x00400093, 0x00200113, 0x002081B3, 0x00000013} (word0 in the LSBs).
   - `busywait`=1 for 8 cycles.
   - `mem_read` high for 6 cycles with `mem_address`=0.
   - `instruction`=0x00000013 while stalled, then 0x00400093 with `busywait`=0.
2. **Sequential hits:** after test 1, `pc`=0x4, 0x8, 0xC on successive cycles.
   - `busywait`=0 throughout and `mem_read` never asserts.
   - `instruction` = 0x00200113, 0x002081B3, 0x00000013.
3. **Conflict:** `pc`=0x80 (index 0, tag 1).
   - Miss with `mem_address`=0x8; refill.
   - Then `pc`=0x0 misses again and `mem_address`=0x0.
4. **Reset mid-refill:** assert `reset` in the 3rd MEM_READ cycle.
   - The next cycle has `mem_read`=0 and state IDLE.
   - Re-presenting `pc`=0x0 misses (valid cleared); no partial line is written.
5. **Zero-latency memory:** `mem_busywait` tied 0.
   - Every miss stalls exactly 3 cycles, with `mem_read` high for exactly 1 cycle.
6. **Index boundary:** fill `pc`=0x70 (index 7), then `pc`=0x80 (index 0).
   - Both hit afterwards.
   - `pc`=0x74 returns word 1 of the first block.
